// File: rtl/rf_arb_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package rf_arb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_NI,
    GNT_NI_FORCE
  } grant_e;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback / NI / register-file write-port bundle for rf_write_arbiter.
interface rf_write_arbiter_if;
  import rf_arb_pkg::*;

  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0]     wb_wd;
  logic                  wb_stall;
  logic                  ni_valid;
  logic [DATA_W-1:0]     ni_data;
  logic                  ni_ready;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0]     rf_wd;
  logic                  ni_win_done;
  logic                  ni_hazard;

  modport master (
    output wb_we, wb_rd, wb_wd, ni_valid, ni_data,
    input  wb_stall, ni_ready, rf_we, rf_rd, rf_wd, ni_win_done, ni_hazard
  );

  modport slave (
    input  wb_we, wb_rd, wb_wd, ni_valid, ni_data,
    output wb_stall, ni_ready, rf_we, rf_rd, rf_wd, ni_win_done, ni_hazard
  );
endinterface

// File: rtl/ni_word_fifo.sv
// NI word FIFO: power-of-two depth, registered full/empty flags, head visible combinationally.
module ni_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic             do_push, do_pop;

  // full is checked before any same-cycle pop, so a full FIFO never accepts.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between writeback and NI window unloading.
// Define RF_ARB_STARVE_EN to enable the NI starvation guard (forced NI grant after STARVE_LIMIT WB wins).
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NI_FIFO_DEPTH = 4,
  parameter int NI_BASE_REG   = 1,
  parameter int NI_LAST_REG   = 7,
  parameter int STARVE_LIMIT  = 4
) (
  input logic               clk,
  input logic               rst,
  rf_write_arbiter_if.slave bus
);
  localparam logic [REG_ADDR_W-1:0] BASE = REG_ADDR_W'(NI_BASE_REG);
  localparam logic [REG_ADDR_W-1:0] LAST = REG_ADDR_W'(NI_LAST_REG);

  grant_e                grant;
  logic                  force_ni;
  logic                  ni_grant;
  logic                  fifo_full, fifo_empty;
  logic [DATA_W-1:0]     fifo_head;
  logic [REG_ADDR_W-1:0] ni_ptr;
  logic                  rf_we_q, win_done_q;
  logic [REG_ADDR_W-1:0] rf_rd_q;
  logic [DATA_W-1:0]     rf_wd_q;

  ni_word_fifo #(
    .DEPTH (NI_FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.ni_valid),
    .push_data (bus.ni_data),
    .pop       (ni_grant),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef RF_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (ni_grant) begin
      starve_cnt <= '0;
    end else if (grant == GNT_WB && !fifo_empty && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`endif

  always_comb begin
    force_ni = 1'b0;
`ifdef RF_ARB_STARVE_EN
    force_ni = !fifo_empty && (starve_cnt == STARVE_MAX);
`endif
    if (force_ni)          grant = GNT_NI_FORCE;
    else if (bus.wb_we)    grant = GNT_WB;
    else if (!fifo_empty)  grant = GNT_NI;
    else                   grant = GNT_NONE;
  end

  assign ni_grant = (grant == GNT_NI) || (grant == GNT_NI_FORCE);

`ifdef RF_ARB_STARVE_EN
  assign bus.wb_stall = bus.wb_we && (grant == GNT_NI_FORCE);
`else
  assign bus.wb_stall = 1'b0;
`endif

  assign bus.ni_hazard = (grant == GNT_WB) && (bus.wb_rd == ni_ptr) && !fifo_empty;
  assign bus.ni_ready  = !fifo_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wd_q    <= '0;
      win_done_q <= 1'b0;
      ni_ptr     <= BASE;
    end else begin
      rf_we_q    <= 1'b0;
      win_done_q <= 1'b0;
      unique case (grant)
        GNT_WB: begin
          // r0 is hardwired zero: the request is consumed but never written.
          rf_we_q <= (bus.wb_rd != '0);
          rf_rd_q <= bus.wb_rd;
          rf_wd_q <= bus.wb_wd;
        end
        GNT_NI, GNT_NI_FORCE: begin
          rf_we_q    <= 1'b1;
          rf_rd_q    <= ni_ptr;
          rf_wd_q    <= fifo_head;
          win_done_q <= (ni_ptr == LAST);
          ni_ptr     <= (ni_ptr == LAST) ? BASE : ni_ptr + REG_ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.rf_we       = rf_we_q;
  assign bus.rf_rd       = rf_rd_q;
  assign bus.rf_wd       = rf_wd_q;
  assign bus.ni_win_done = win_done_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: vector table, directed corner sequences, randomized run vs. queue model.
module tb_rf_write_arbiter;
  localparam int DEPTH = 4;
  localparam int BASE  = 1;
  localparam int LAST  = 7;
  localparam int LIMIT = 4;
`ifdef RF_ARB_STARVE_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  rf_write_arbiter_if bus();

  rf_write_arbiter #(
    .NI_FIFO_DEPTH (DEPTH),
    .NI_BASE_REG   (BASE),
    .NI_LAST_REG   (LAST),
    .STARVE_LIMIT  (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: pending NI words, next window register, consecutive WB wins.
  logic [31:0] mq[$];
  int          mptr;
  int          mstarve;
  bit          e_we, e_done;
  int          e_rd;
  logic [31:0] e_wd;
  bit          last_stall;

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;
    logic        ni_valid;
    logic [31:0] ni_data;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wd;
    logic        exp_done;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 0 none, 1 writeback, 2 NI, 3 forced NI
  function automatic int model_grant(input bit we);
    if (GUARD && mstarve == LIMIT && mq.size() > 0) return 3;
    if (we) return 1;
    if (mq.size() > 0) return 2;
    return 0;
  endfunction

  task automatic cycle(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                       input logic v, input logic [31:0] d);
    int g;
    bit acc;
    bus.wb_we    = we;
    bus.wb_rd    = rd;
    bus.wb_wd    = wd;
    bus.ni_valid = v;
    bus.ni_data  = d;
    @(negedge clk);
    g   = model_grant(we);
    acc = v && (mq.size() < DEPTH);
    chk("ni_ready", 32'(bus.ni_ready), 32'(mq.size() < DEPTH));
    chk("wb_stall", 32'(bus.wb_stall), 32'(we && g == 3));
    chk("ni_hazard", 32'(bus.ni_hazard), 32'(g == 1 && int'(rd) == mptr && mq.size() > 0));
    last_stall = bus.wb_stall;
    @(posedge clk);
    e_we   = 1'b0;
    e_done = 1'b0;
    if (g == 1) begin
      e_we = (rd != 5'd0);
      e_rd = int'(rd);
      e_wd = wd;
      if (GUARD && mq.size() > 0 && mstarve < LIMIT) mstarve++;
    end else if (g >= 2) begin
      e_wd    = mq.pop_front();
      e_we    = 1'b1;
      e_rd    = mptr;
      e_done  = (mptr == LAST);
      mptr    = (mptr == LAST) ? BASE : mptr + 1;
      mstarve = 0;
    end
    if (acc) mq.push_back(d);
    #1;
    chk("rf_we", 32'(bus.rf_we), 32'(e_we));
    if (e_we) begin
      chk("rf_rd", 32'(bus.rf_rd), 32'(e_rd));
      chk("rf_wd", bus.rf_wd, e_wd);
    end
    chk("ni_win_done", 32'(bus.ni_win_done), 32'(e_done));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
  endtask

  // Called at posedge+1; asserts reset asynchronously and checks outputs clear at once.
  task automatic do_reset();
    bus.wb_we    = 1'b0;
    bus.wb_rd    = '0;
    bus.wb_wd    = '0;
    bus.ni_valid = 1'b0;
    bus.ni_data  = '0;
    rst = 1'b1;
    #2;
    chk("rst_rf_we", 32'(bus.rf_we), 32'h0);
    chk("rst_rf_rd", 32'(bus.rf_rd), 32'h0);
    chk("rst_rf_wd", bus.rf_wd, 32'h0);
    chk("rst_win_done", 32'(bus.ni_win_done), 32'h0);
    chk("rst_hazard", 32'(bus.ni_hazard), 32'h0);
    chk("rst_stall", 32'(bus.wb_stall), 32'h0);
    mq.delete();
    mptr    = BASE;
    mstarve = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ni_ready", 32'(bus.ni_ready), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int wb_writes, stalls, ni_idx, sent, ready_drop, ni_writes;
    logic [31:0] seen[$];
    logic        we_r, v_r;
    logic [4:0]  rd_r;

    //             we  rd    wd     valid data      exp_we rd   wd     done
    vecs[0]  = '{1'b0, 5'd0, 32'h0, 1'b1, 32'hA1, 1'b0, 5'd0, 32'h00, 1'b0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0, 1'b1, 32'hA2, 1'b1, 5'd1, 32'hA1, 1'b0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0, 1'b1, 32'hA3, 1'b1, 5'd2, 32'hA2, 1'b0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0, 1'b1, 32'hA4, 1'b1, 5'd3, 32'hA3, 1'b0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0, 1'b1, 32'hA5, 1'b1, 5'd4, 32'hA4, 1'b0};
    vecs[5]  = '{1'b0, 5'd0, 32'h0, 1'b1, 32'hA6, 1'b1, 5'd5, 32'hA5, 1'b0};
    vecs[6]  = '{1'b0, 5'd0, 32'h0, 1'b1, 32'hA7, 1'b1, 5'd6, 32'hA6, 1'b0};
    vecs[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h00, 1'b1, 5'd7, 32'hA7, 1'b1};
    vecs[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h00, 1'b0, 5'd0, 32'h00, 1'b0};
    vecs[9]  = '{1'b0, 5'd0, 32'h0, 1'b1, 32'hA8, 1'b0, 5'd0, 32'h00, 1'b0};
    vecs[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h00, 1'b1, 5'd1, 32'hA8, 1'b0};

    #1;
    do_reset();

    // Window fill r1..r7, wrap back to r1.
    for (int i = 0; i < 11; i++) begin
      cycle(vecs[i].wb_we, vecs[i].wb_rd, vecs[i].wb_wd, vecs[i].ni_valid, vecs[i].ni_data);
      chk("tbl_rf_we", 32'(bus.rf_we), 32'(vecs[i].exp_we));
      if (vecs[i].exp_we) begin
        chk("tbl_rf_rd", 32'(bus.rf_rd), 32'(vecs[i].exp_rd));
        chk("tbl_rf_wd", bus.rf_wd, vecs[i].exp_wd);
      end
      chk("tbl_win_done", 32'(bus.ni_win_done), 32'(vecs[i].exp_done));
    end

    // Starvation: one queued NI word against 8 cycles of writeback to r9.
    do_reset();
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 32'h5A);
    wb_writes = 0;
    stalls    = 0;
    ni_idx    = -1;
    for (int i = 0; i < 9; i++) begin
      cycle(i < 8, 5'd9, 32'h100 + 32'(i), 1'b0, 32'h0);
      if (bus.rf_we && bus.rf_rd == 5'd9) wb_writes++;
      if (bus.rf_we && bus.rf_rd == 5'd1 && ni_idx < 0) ni_idx = i;
      if (last_stall) stalls++;
    end
    chk("starve_wb_writes", 32'(wb_writes), GUARD ? 32'd7 : 32'd8);
    chk("starve_stalls", 32'(stalls), GUARD ? 32'd1 : 32'd0);
    chk("starve_ni_cycle", 32'(ni_idx), GUARD ? 32'd4 : 32'd8);

    // Back-pressure: 6 words offered while writeback holds the port.
    do_reset();
    sent       = 0;
    ready_drop = -1;
    ni_writes  = 0;
    seen.delete();
    for (int i = 0; i < 30; i++) begin
      bit rdy;
      rdy = bus.ni_ready;
      if (!rdy && ready_drop < 0) ready_drop = sent;
      cycle(i < 12, 5'd10, 32'h200 + 32'(i), sent < 6, 32'hB1 + 32'(sent));
      if (rdy && sent < 6) sent++;
      if (bus.rf_we && bus.rf_rd != 5'd10) seen.push_back(bus.rf_wd);
    end
    chk("bp_accepted_at_full", 32'(ready_drop), 32'd4);
    chk("bp_ni_writes", 32'(seen.size()), 32'd6);
    for (int k = 0; k < seen.size(); k++) chk("bp_order", seen[k], 32'hB1 + 32'(k));

    // Writeback to r0 is consumed without a write; queued NI word waits a cycle.
    do_reset();
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 32'hC1);
    cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'h0);
    chk("r0_no_write", 32'(bus.rf_we), 32'h0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    chk("r0_ni_we", 32'(bus.rf_we), 32'h1);
    chk("r0_ni_rd", 32'(bus.rf_rd), 32'h1);
    chk("r0_ni_wd", bus.rf_wd, 32'hC1);

    // Reset mid-window: pointer restarts at r1, queued words discarded.
    do_reset();
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 32'hD1);
    cycle(1'b1, 5'd12, 32'h12, 1'b1, 32'hD2);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 32'hD3);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 32'hD4);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 32'hD5);
    do_reset();
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 32'hE1);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    chk("post_rst_we", 32'(bus.rf_we), 32'h1);
    chk("post_rst_rd", 32'(bus.rf_rd), 32'h1);
    chk("post_rst_wd", bus.rf_wd, 32'hE1);
    idle(2);

    // Randomized traffic against the queue model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      we_r = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 30));
      rd_r = ($urandom_range(0, 3) == 0) ? 5'(mptr) : 5'($urandom_range(0, 31));
      v_r  = ($urandom_range(0, 99) < 60);
      cycle(we_r, rd_r, $urandom, v_r, $urandom);
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Arbiter and sequencer for the register file's single write port. It shares the port between the pipeline writeback stage and the network interface (NI), which unloads received words into a fixed register window. NI words are buffered in a small FIFO and written to consecutive registers, wrapping inside the window. The block replaces direct drive of the register file's write-enable, address and data inputs.

## Interface
- NI_FIFO_DEPTH, 4: NI word FIFO entries; power of two, ≥2.
- NI_BASE_REG, 1: first register of the NI window.
- NI_LAST_REG, 7: last register of the NI window; must be > NI_BASE_REG and ≤ 31.
- STARVE_LIMIT, 4: consecutive writeback wins allowed while NI data waits.

- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- wb_we  in  1  writeback write request.
- wb_rd  in  5  writeback destination register.
- wb_wd  in  32  writeback data.
- wb_stall  out  1  combinational; writeback must hold its request this cycle.
- ni_valid  in  1  NI word offered.
- ni_data  in  32  NI word.
- ni_ready  out  1  FIFO can accept; a word transfers when ni_valid && ni_ready.
- rf_we  out  1  register file write enable.
- rf_rd  out  5  register file write address.
- rf_wd  out  32  register file write data.
- ni_win_done  out  1  one-cycle pulse when NI_LAST_REG is written.
- ni_hazard  out  1  one-cycle pulse when a writeback targets the register the NI writes next.

## Operation
- Grant per cycle, in priority order:
  - GNT_NI_FORCE: starve_cnt == STARVE_LIMIT and FIFO non-empty.
  - GNT_WB: wb_we.
  - GNT_NI: FIFO non-empty.
  - GNT_NONE: otherwise.
- wb_stall = wb_we && (grant == GNT_NI_FORCE).
- Writeback to register 0: granted and consumed, but rf_we stays 0 (r0 is hardwired zero).
- NI grant:
  - Pops the FIFO head and writes it to ni_ptr.
  - ni_ptr increments. After NI_LAST_REG it wraps to NI_BASE_REG, and ni_win_done pulses with that write.
- starve_cnt:
  - Increments, saturating, when the FIFO is non-empty and writeback wins.
  - Clears on any NI grant.
  - Holds when the FIFO is empty.
- ni_hazard pulses when a granted writeback has wb_rd == ni_ptr and the FIFO is non-empty. The write still proceeds; the pulse is advisory, for debug and counters.
- FIFO:
  - ni_ready = !full, computed from registered state.
  - Push and pop in the same cycle are allowed when non-empty; occupancy is then unchanged.
  - No push is accepted while full, even if a pop occurs that cycle.

## Timing
- Arbitration is combinational on the current inputs and FIFO state. rf_we, rf_rd, rf_wd and ni_win_done are registered, so they are valid one cycle after the grant.
- NI word latency: accepted in cycle N, written to the register file at cycle N+2 at earliest (registered FIFO, then registered output).
- wb_stall is same-cycle. Writeback latency is one cycle when not stalled.
- Reset, asynchronous and at any time, including mid-window:
  - FIFO emptied; buffered words are discarded.
  - ni_ptr = NI_BASE_REG; starve_cnt = 0.
  - rf_we = 0, rf_rd = 0, rf_wd = 0.
  - ni_win_done = 0, ni_hazard = 0, wb_stall = 0.
  - ni_ready = 1 in the first cycle after reset deasserts.

## Configuration
- RF_ARB_STARVE_EN defined:
  - Starvation guard active as described.
- RF_ARB_STARVE_EN undefined:
  - starve_cnt and GNT_NI_FORCE are removed; writeback has strict priority.
  - wb_stall is tied to 0.
  - NI words drain only on cycles with no writeback request.

## Structure
- Shared package rf_arb_pkg contains:
  - Grant enum: GNT_NONE, GNT_WB, GNT_NI, GNT_NI_FORCE.
  - REG_ADDR_W = 5 and DATA_W = 32.
- One sub-module, ni_word_fifo: parameterized depth, registered full/empty, push/pop interface.

## Test plan
- Reset, then 7 NI words 0xA1..0xA7 with wb_we = 0 → r1..r7 written in order, consecutive cycles from N+2; ni_win_done pulses with the r7 write; ni_ptr back to 1.
- wb_we held high (rd = 9) for 8 cycles with 1 NI word queued, guard enabled → 4 WB writes, then wb_stall = 1 for one cycle and the NI word goes to r1, then WB resumes.
- Same stimulus with RF_ARB_STARVE_EN undefined → 8 WB writes, wb_stall never high, NI word written in cycle 9.
- 6 NI words pushed back-to-back while WB blocks the port (depth 4) → ni_ready drops after 4 accepted; no words are lost or duplicated.
- wb_we with wb_rd = 0, data 0xFFFF_FFFF → rf_we stays 0; an NI word pending in the same cycle waits one cycle.
- rst asserted after 3 of 7 NI words are written, 2 still queued → all outputs 0 immediately; the next NI word goes to r1.
